// File: rtl/apb_master_port.sv
// apb_master_port
// -----------------------------------------------------------------------------
// APB initiator. It accepts one register-access request at a time on a
// valid/ready request channel and runs it as a single APB transfer: one SETUP
// cycle, then ACCESS until PREADY. The result goes out on a valid/ready
// response channel. A wait-state timeout aborts transfers to a slave that
// never raises PREADY.
//
// Parameters
//   APB_ADDR_WIDTH  width of req_addr_i / PADDR_o
//   TIMEOUT_CYCLES  maximum number of consecutive ACCESS cycles with PREADY=0
//                   before the transfer is aborted. 0 disables the timeout.
//                   Legal range is 0..65535.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   req_valid_i/ready_o     request handshake; ready only in IDLE
//   req_addr_i/wdata_i      request address and write data
//   req_write_i             1 = write, 0 = read
//   rsp_valid_o/ready_i     response handshake
//   rsp_rdata_o             read data (0 for writes and for timeouts)
//   rsp_err_o               PSLVERR, or timeout
//   rsp_timeout_o           transfer aborted by timeout
//   PADDR_o..PENABLE_o      APB request side
//   PRDATA_i..PSLVERR_i     APB completion side
// -----------------------------------------------------------------------------
module apb_master_port #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      req_write_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [31:0]               PWDATA_o,
  output logic                      PWRITE_o,
  output logic                      PSEL_o,
  output logic                      PENABLE_o,
  input  logic [31:0]               PRDATA_i,
  input  logic                      PREADY_i,
  input  logic                      PSLVERR_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_VAL = 16'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        timeout_hit;

  // wait_cnt holds the number of PREADY=0 ACCESS cycles already elapsed, so
  // it equals TO_VAL in the (TIMEOUT_CYCLES+1)-th ACCESS cycle, the one that
  // aborts. PREADY is checked first, so a slave that completes in that same
  // cycle still finishes normally.
  assign timeout_hit = TO_EN && (wait_cnt == TO_VAL);

  // The handshake and APB strobes decode straight from the state, so reset
  // clears them on the same edge that returns the FSM to IDLE.
  assign req_ready_o = (state == S_IDLE);
  assign PSEL_o      = (state == S_SETUP) || (state == S_ACCESS);
  assign PENABLE_o   = (state == S_ACCESS);
  assign rsp_valid_o = (state == S_RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      PADDR_o       <= '0;
      PWDATA_o      <= '0;
      PWRITE_o      <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // The APB address/data registers load only here. They hold their
          // values through SETUP and ACCESS and keep them after the transfer.
          if (req_valid_i) begin
            PADDR_o  <= req_addr_i;
            PWDATA_o <= req_wdata_i;
            PWRITE_o <= req_write_i;
            wait_cnt <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: state <= S_ACCESS;
        S_ACCESS: begin
          if (PREADY_i) begin
            rsp_err_o     <= PSLVERR_i;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= PWRITE_o ? 32'd0 : PRDATA_i;
            state         <= S_RESP;
          end else if (timeout_hit) begin
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_rdata_o   <= 32'd0;
            state         <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_RESP: if (rsp_ready_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
